// File: rtl/lif_net_pipe.sv
// Two-layer leaky-integrate-and-fire network: N_CH hidden neurons feed one output
// neuron through programmable signed weights, with a 3-stage step pipeline.

module lif_neuron #(
  parameter int W          = 8,
  parameter int THRESH     = 128,
  parameter int BETA_SHIFT = 3,
  parameter int REFRAC     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] cur,
  output logic [W-1:0] u,
  output logic         spike
);
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic [W:0]    SAT = {1'b0, {W{1'b1}}};
  localparam logic [W:0]    TH  = (W+1)'(THRESH);
  localparam logic [RW-1:0] RF  = RW'(REFRAC);

  logic [RW-1:0] r;
  logic [W:0]    s_raw;
  logic [W:0]    s;
  logic [W:0]    diff;
  logic          fire;

  // One extra bit holds leak+current before saturation.
  always_comb begin
    s_raw = {1'b0, u} - ({1'b0, u} >> BETA_SHIFT) + {1'b0, cur};
    s     = (s_raw > SAT) ? SAT : s_raw;
    fire  = (s >= TH);
    diff  = s - TH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      u     <= '0;
      r     <= '0;
      spike <= 1'b0;
    end else if (en) begin
      if (r != '0) begin
        r     <= r - RW'(1);
        spike <= 1'b0;
      end else if (fire) begin
        u     <= diff[W-1:0];
        r     <= RF;
        spike <= 1'b1;
      end else begin
        u     <= s[W-1:0];
        spike <= 1'b0;
      end
    end
  end
endmodule

module lif_net_pipe #(
  parameter int N_CH       = 8,
  parameter int W          = 8,
  parameter int THRESH     = 128,
  parameter int BETA_SHIFT = 3,
  parameter int REFRAC     = 2,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      step,
  input  logic [N_CH*W-1:0]         current,
  input  logic                      wt_we,
  input  logic [$clog2(N_CH)-1:0]   wt_addr,
  input  logic [W-1:0]              wt_data,
  input  logic                      cnt_clr,
  output logic [N_CH-1:0]           hid_spike,
  output logic [N_CH*W-1:0]         hid_state,
  output logic                      spike_out,
  output logic [W-1:0]              state_out,
  output logic                      out_valid,
  output logic [CNT_W-1:0]          spike_count
);
  localparam int AW = $clog2(N_CH);
  localparam int SW = W + AW + 1;
  localparam logic signed [SW-1:0] SMAX = SW'((1 << W) - 1);

  logic [W-1:0]          wt [N_CH];
  logic                  addr_ok;
  logic signed [SW-1:0]  sum_c;
  logic [W-1:0]          sum_clamp;
  logic [W-1:0]          sum_q;
  logic                  v1;
  logic                  v2;

  for (genvar g = 0; g < N_CH; g++) begin : g_hid
    lif_neuron #(
      .W(W), .THRESH(THRESH), .BETA_SHIFT(BETA_SHIFT), .REFRAC(REFRAC)
    ) u_hid (
      .clk   (clk),
      .rst   (rst),
      .en    (step),
      .cur   (current[g*W +: W]),
      .u     (hid_state[g*W +: W]),
      .spike (hid_spike[g])
    );
  end

  if (N_CH == (1 << AW)) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_chk
    assign addr_ok = (wt_addr < AW'(N_CH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CH; i++) wt[i] <= W'(1);
    end else if (wt_we && addr_ok) begin
      wt[wt_addr] <= wt_data;
    end
  end

  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < N_CH; i++)
      if (hid_spike[i]) sum_c = sum_c + SW'($signed(wt[i]));
    if (sum_c[SW-1])      sum_clamp = '0;
    else if (sum_c > SMAX) sum_clamp = '1;
    else                   sum_clamp = sum_c[W-1:0];
  end

  // v1/v2 track the step through the sum and output stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      sum_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      v1        <= step;
      v2        <= v1;
      out_valid <= v2;
      if (v1) sum_q <= sum_clamp;
    end
  end

  lif_neuron #(
    .W(W), .THRESH(THRESH), .BETA_SHIFT(BETA_SHIFT), .REFRAC(REFRAC)
  ) u_out (
    .clk   (clk),
    .rst   (rst),
    .en    (v2),
    .cur   (sum_q),
    .u     (state_out),
    .spike (spike_out)
  );

  always_ff @(posedge clk) begin
    if (rst || cnt_clr)
      spike_count <= '0;
    else if (out_valid && spike_out && (spike_count != '1))
      spike_count <= spike_count + CNT_W'(1);
  end
endmodule

// File: tb/tb_lif_net_pipe.sv
// Directed bench for lif_net_pipe (default parameters, 4-bit spike counter).

module tb_lif_net_pipe;
  localparam int N_CH  = 8;
  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                step;
  logic [N_CH*W-1:0]   current;
  logic                wt_we;
  logic [2:0]          wt_addr;
  logic [W-1:0]        wt_data;
  logic                cnt_clr;
  logic [N_CH-1:0]     hid_spike;
  logic [N_CH*W-1:0]   hid_state;
  logic                spike_out;
  logic [W-1:0]        state_out;
  logic                out_valid;
  logic [CNT_W-1:0]    spike_count;

  int n_chk  = 0;
  int n_pass = 0;

  lif_net_pipe #(.N_CH(N_CH), .W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .step       (step),
    .current    (current),
    .wt_we      (wt_we),
    .wt_addr    (wt_addr),
    .wt_data    (wt_data),
    .cnt_clr    (cnt_clr),
    .hid_spike  (hid_spike),
    .hid_state  (hid_state),
    .spike_out  (spike_out),
    .state_out  (state_out),
    .out_valid  (out_valid),
    .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_all_wt(input logic [W-1:0] val);
    for (int i = 0; i < N_CH; i++) begin
      wt_we = 1'b1; wt_addr = 3'(i); wt_data = val;
      tick();
    end
    wt_we = 1'b0;
  endtask

  int hs [6] = '{64, 120, 41, 41, 41, 100};
  bit sp [6] = '{0, 0, 1, 0, 0, 0};

  initial begin
    rst = 1'b1; step = 1'b1; current = {N_CH{8'd255}};
    wt_we = 1'b0; wt_addr = '0; wt_data = '0; cnt_clr = 1'b0;

    // 1: reset with step and full current
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rst_hid_state", hid_state, 64'd0);
      check("rst_hid_spike", {56'd0, hid_spike}, 64'd0);
      check("rst_valid", {63'd0, out_valid}, 64'd0);
      check("rst_count", {60'd0, spike_count}, 64'd0);
    end
    rst = 1'b0; step = 1'b0; current = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_step_lost", {63'd0, out_valid}, 64'd0);
    end
    check("rst_state_out", {56'd0, state_out}, 64'd0);

    // 2: ch0 = 64 every step
    current = 64'd64;
    step = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("c2_u0_s%0d", k + 1), {56'd0, hid_state[7:0]}, 64'(hs[k]));
      check($sformatf("c2_sp0_s%0d", k + 1), {63'd0, hid_spike[0]}, 64'(sp[k]));
    end
    step = 1'b0;
    tick(); tick(); tick();
    check("c2_state_out", {56'd0, state_out}, 64'd1);
    check("c2_count", {60'd0, spike_count}, 64'd0);

    // 3: all 255, weights 16, one step
    do_reset();
    write_all_wt(8'd16);
    current = {N_CH{8'd255}};
    step = 1'b1;
    tick();
    step = 1'b0;
    check("c3_hid_spike", {56'd0, hid_spike}, 64'hFF);
    check("c3_hid_state", hid_state, {N_CH{8'd127}});
    check("c3_valid_t0", {63'd0, out_valid}, 64'd0);
    tick();
    check("c3_valid_t1", {63'd0, out_valid}, 64'd0);
    tick();
    check("c3_valid_t2", {63'd0, out_valid}, 64'd1);
    check("c3_spike_out", {63'd0, spike_out}, 64'd1);
    check("c3_state_out", {56'd0, state_out}, 64'd0);
    tick();
    check("c3_valid_t3", {63'd0, out_valid}, 64'd0);
    check("c3_count", {60'd0, spike_count}, 64'd1);

    // 4: second step, hidden neurons refractory
    step = 1'b1;
    tick();
    step = 1'b0;
    check("c4_hid_spike", {56'd0, hid_spike}, 64'd0);
    check("c4_hid_state", hid_state, {N_CH{8'd127}});
    tick(); tick();
    check("c4_valid", {63'd0, out_valid}, 64'd1);
    check("c4_spike_out", {63'd0, spike_out}, 64'd0);
    check("c4_state_out", {56'd0, state_out}, 64'd0);

    // 5: wt[0] = -100 written with the step, only ch0 driven
    do_reset();
    current = 64'd255;
    step = 1'b1; wt_we = 1'b1; wt_addr = 3'd0; wt_data = 8'h9C;
    tick();
    step = 1'b0; wt_we = 1'b0;
    check("c5_hid_spike", {56'd0, hid_spike}, 64'd1);
    tick(); tick();
    check("c5_valid", {63'd0, out_valid}, 64'd1);
    check("c5_spike_out", {63'd0, spike_out}, 64'd0);
    check("c5_state_out", {56'd0, state_out}, 64'd0);

    // 5b: write coinciding with the sum edge uses the old weight (S = 8)
    do_reset();
    current = {N_CH{8'd255}};
    step = 1'b1;
    tick();
    step = 1'b0; wt_we = 1'b1; wt_addr = 3'd0; wt_data = 8'h9C;
    tick();
    wt_we = 1'b0;
    tick();
    check("c5b_valid", {63'd0, out_valid}, 64'd1);
    check("c5b_state_out", {56'd0, state_out}, 64'd8);

    // 6: output spikes every third step; 4-bit counter saturates
    do_reset();
    write_all_wt(8'd16);
    current = {N_CH{8'd255}};
    step = 1'b1;
    for (int k = 0; k < 30; k++) tick();
    step = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("c6_count_mid", {60'd0, spike_count}, 64'd10);
    step = 1'b1;
    for (int k = 0; k < 30; k++) tick();
    step = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("c6_count_sat", {60'd0, spike_count}, 64'd15);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick(); tick();
    check("c6_clr_valid", {63'd0, out_valid}, 64'd1);
    check("c6_clr_spike", {63'd0, spike_out}, 64'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("c6_count_clr", {60'd0, spike_count}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
